// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus bridge.
package lsu_pkg;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_t;

    // Access width from funct3; both 2'b10 and 2'b11 are word accesses.
    function automatic lsu_size_t size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_bridge_if.sv
// Request/response data bus between the load/store bridge and memory.
interface lsu_bus_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  bus_req_valid;
    logic                  bus_req_ready;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [3:0]            bus_be;
    logic [31:0]           bus_wdata;
    logic                  bus_rsp_valid;
    logic [31:0]           bus_rsp_data;
    logic                  bus_rsp_err;

    modport master (
        output bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err
    );

    modport slave (
        input  bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Lane steering: store byte enables / write data / misalign flag, and
// load lane selection with sign or zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_t   i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wr_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    input  logic [31:0] i_rsp_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_offset,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = i_rsp_data[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_lane[i_ld_offset];
    // Halfword loads are always 2-byte aligned, so only offset bit 1 matters.
    assign w_half = i_ld_offset[1] ? i_rsp_data[31:16] : i_rsp_data[15:0];

    // Store side: position enables and replicate data across lanes
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = i_wr_data;
        o_misalign = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wr_data[7:0]}};
            end
            SZ_HALF: begin
                o_be       = 4'b0011 << {i_offset[1], 1'b0};
                o_wdata    = {2{i_wr_data[15:0]}};
                o_misalign = i_offset[0];
            end
            default: begin
                o_be       = 4'b1111;
                o_misalign = |i_offset;
            end
        endcase
    end

    // Load side: extend the selected lane; unlisted codes act as LW
    always_comb begin
        o_ld_data = i_rsp_data;
        case (i_ld_funct3)
            F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_ld_data = {24'd0, w_byte};
            F3_LHU:  o_ld_data = {16'd0, w_half};
            F3_LW:   o_ld_data = i_rsp_data;
            default: o_ld_data = i_rsp_data;
        endcase
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: turns each core data access into one bus transaction,
// stalls the core until it completes, and reports misalign/bus faults.
module lsu_bus_bridge
    import lsu_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wr_data,
    output logic [31:0]           o_rd_data,
    output logic                  o_stall,
    output logic                  o_fault_misalign,
    output logic                  o_bus_err,
    lsu_bus_bridge_if.master      bus
);

    // Last counter value before giving up on a response
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    lsu_state_t            r_state;
    lsu_state_t            w_state_next;
    logic [15:0]           r_cnt;
    logic                  r_req_valid;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rd_data;
    logic                  r_bus_err;
    logic [2:0]            r_ld_funct3;
    logic [1:0]            r_ld_offset;

    logic                  w_access;
    lsu_size_t             w_size;
    logic                  w_misalign;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_ld_data;
    logic                  w_rsp_take;
    logic                  w_timeout;

    assign w_access = i_mem_read | i_mem_write;
    assign w_size   = size_of(i_funct3);

    lsu_align u_align (
        .i_size      (w_size),
        .i_offset    (i_addr[1:0]),
        .i_wr_data   (i_wr_data),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_misalign  (w_misalign),
        .i_rsp_data  (bus.bus_rsp_data),
        .i_ld_funct3 (r_ld_funct3),
        .i_ld_offset (r_ld_offset),
        .o_ld_data   (w_ld_data)
    );

    // Core-facing status: a misaligned access is rejected without stalling
    assign o_fault_misalign = w_access & w_misalign;
    assign o_stall          = w_access & ~w_misalign & (r_state != ST_DONE);
    assign o_rd_data        = r_rd_data;
    assign o_bus_err        = r_bus_err;

    assign bus.bus_req_valid = r_req_valid;
    assign bus.bus_we        = r_we;
    assign bus.bus_addr      = r_addr;
    assign bus.bus_be        = r_be;
    assign bus.bus_wdata     = r_wdata;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a response takes priority over the timeout
    always_comb begin
        w_state_next = r_state;
        w_rsp_take   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access && !w_misalign) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.bus_req_ready) begin
                    w_state_next = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (bus.bus_rsp_valid) begin
                    w_rsp_take   = 1'b1;
                    w_state_next = ST_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request fields, timeout counter, and response capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= 16'd0;
            r_req_valid <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= 4'b0000;
            r_wdata     <= 32'd0;
            r_rd_data   <= 32'd0;
            r_bus_err   <= 1'b0;
            r_ld_funct3 <= 3'b000;
            r_ld_offset <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_state_next == ST_REQ) begin
                        r_req_valid <= 1'b1;
                        r_we        <= i_mem_write;
                        r_addr      <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_be        <= w_be;
                        r_wdata     <= w_wdata;
                        r_ld_funct3 <= i_funct3;
                        r_ld_offset <= i_addr[1:0];
                    end
                end
                ST_REQ: begin
                    if (bus.bus_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_cnt       <= 16'd0;
                    end
                end
                ST_WAIT_RSP: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_rsp_take) begin
                        if (!r_we) begin
                            r_rd_data <= w_ld_data;
                        end
                        r_bus_err <= bus.bus_rsp_err;
                    end else if (w_timeout) begin
                        r_rd_data <= 32'd0;
                        r_bus_err <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_bus_err <= 1'b0;
                end
                default: begin
                    r_bus_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: directed scenarios plus randomized
// accesses, checked cycle by cycle against a behavioural model.
module tb_lsu_bus_bridge;
    import lsu_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        stall;
    logic        fault_misalign;
    logic        bus_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model_rd = 32'd0;

    lsu_bus_bridge_if #(.ADDR_WIDTH(32)) bus_if ();

    lsu_bus_bridge #(.TIMEOUT(TIMEOUT), .ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_mem_read       (mem_read),
        .i_mem_write      (mem_write),
        .i_funct3         (funct3),
        .i_addr           (addr),
        .i_wr_data        (wr_data),
        .o_rd_data        (rd_data),
        .o_stall          (stall),
        .o_fault_misalign (fault_misalign),
        .o_bus_err        (bus_err),
        .bus              (bus_if)
    );

    always #5 clk = ~clk;

    // Reference: load result from whole response word
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(off))) & 32'h0000_00FF;
        h = (w >> (8 * int'(off))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'(1 << int'(off));
            2'b01:   return 4'(3 << int'(off));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return (wd & 32'hFF) * 32'h0101_0101;
            2'b01:   return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_err   = 1'b0;
    endtask

    // One full access; the model predicts REQ/WAIT/DONE lengths from the delays
    task automatic run_access(input string tag, input logic is_wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int rdy_dly, input int rsp_dly, input logic [31:0] rsp_word,
                              input logic rsp_e, input logic no_rsp, input logic idle_after);
        int          w_len, req_end, wait_beg, total;
        logic        in_req, in_wait, in_done, exp_err;
        logic [31:0] exp_addr, exp_wd;
        logic [3:0]  exp_be;
        w_len    = no_rsp ? TIMEOUT : rsp_dly + 1;
        req_end  = rdy_dly + 1;
        wait_beg = rdy_dly + 2;
        total    = wait_beg + w_len + 1;
        exp_addr = a & 32'hFFFF_FFFC;
        exp_be   = ref_be(f3, a[1:0]);
        exp_wd   = ref_wdata(f3, wd);
        exp_err  = no_rsp | rsp_e;
        if (no_rsp) model_rd = 32'd0;
        else if (!is_wr) model_rd = ref_load(f3, a[1:0], rsp_word);
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            mem_read  = is_wr ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_write = is_wr;
            funct3    = f3;
            addr      = a;
            wr_data   = wd;
            in_req  = (c >= 1) && (c <= req_end);
            in_wait = (c >= wait_beg) && (c < wait_beg + w_len);
            in_done = (c == total - 1);
            bus_if.bus_req_ready = in_req ? (c == req_end) : 1'($urandom_range(0, 1));
            if (in_wait) bus_if.bus_rsp_valid = !no_rsp && (c == wait_beg + rsp_dly);
            else         bus_if.bus_rsp_valid = ($urandom_range(0, 3) == 0);
            bus_if.bus_rsp_data = (in_wait && bus_if.bus_rsp_valid) ? rsp_word : $urandom;
            bus_if.bus_rsp_err  = (in_wait && bus_if.bus_rsp_valid) ? rsp_e : 1'($urandom_range(0, 1));
            #1;
            n_checks++; if (stall !== !in_done) $display("FAIL %s stall c=%0d got %b want %b", tag, c, stall, !in_done); else n_pass++;
            n_checks++; if (bus_if.bus_req_valid !== in_req) $display("FAIL %s req_valid c=%0d got %b want %b", tag, c, bus_if.bus_req_valid, in_req); else n_pass++;
            n_checks++; if (fault_misalign !== 1'b0) $display("FAIL %s fault_misalign c=%0d got %b want 0", tag, c, fault_misalign); else n_pass++;
            n_checks++; if (bus_err !== (in_done & exp_err)) $display("FAIL %s bus_err c=%0d got %b want %b", tag, c, bus_err, in_done & exp_err); else n_pass++;
            if (in_req) begin
                n_checks++; if (bus_if.bus_addr !== exp_addr) $display("FAIL %s bus_addr c=%0d got %h want %h", tag, c, bus_if.bus_addr, exp_addr); else n_pass++;
                n_checks++; if (bus_if.bus_we !== is_wr) $display("FAIL %s bus_we c=%0d got %b want %b", tag, c, bus_if.bus_we, is_wr); else n_pass++;
                n_checks++; if (bus_if.bus_be !== exp_be) $display("FAIL %s bus_be c=%0d got %b want %b", tag, c, bus_if.bus_be, exp_be); else n_pass++;
                n_checks++; if (bus_if.bus_wdata !== exp_wd) $display("FAIL %s bus_wdata c=%0d got %h want %h", tag, c, bus_if.bus_wdata, exp_wd); else n_pass++;
            end
            if (in_done) begin
                n_checks++; if (rd_data !== model_rd) $display("FAIL %s rd_data got %h want %h", tag, rd_data, model_rd); else n_pass++;
            end
        end
        if (idle_after) begin
            @(negedge clk);
            idle_inputs();
            #1;
            n_checks++; if (stall !== 1'b0) $display("FAIL %s idle stall got %b want 0", tag, stall); else n_pass++;
            n_checks++; if (bus_err !== 1'b0) $display("FAIL %s idle bus_err got %b want 0", tag, bus_err); else n_pass++;
            n_checks++; if (bus_if.bus_req_valid !== 1'b0) $display("FAIL %s idle req_valid got %b want 0", tag, bus_if.bus_req_valid); else n_pass++;
            n_checks++; if (rd_data !== model_rd) $display("FAIL %s idle rd_data got %h want %h", tag, rd_data, model_rd); else n_pass++;
        end
        $display("txn %s we=%0d f3=%0d addr=%h wd=%h rdy=%0d rsp=%0d err=%0d to=%0d rd=%h",
                 tag, is_wr, f3, a, wd, rdy_dly, rsp_dly, rsp_e, no_rsp, model_rd);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        funct3 = 3'd0; addr = 32'd0; wr_data = 32'd0;
        bus_if.bus_rsp_data = 32'd0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (bus_if.bus_req_valid !== 1'b0) $display("FAIL reset req_valid got %b want 0", bus_if.bus_req_valid); else n_pass++;
        n_checks++; if (bus_if.bus_we !== 1'b0) $display("FAIL reset bus_we got %b want 0", bus_if.bus_we); else n_pass++;
        n_checks++; if (bus_if.bus_be !== 4'd0) $display("FAIL reset bus_be got %b want 0000", bus_if.bus_be); else n_pass++;
        n_checks++; if (bus_if.bus_addr !== 32'd0) $display("FAIL reset bus_addr got %h want 0", bus_if.bus_addr); else n_pass++;
        n_checks++; if (bus_if.bus_wdata !== 32'd0) $display("FAIL reset bus_wdata got %h want 0", bus_if.bus_wdata); else n_pass++;
        n_checks++; if (rd_data !== 32'd0) $display("FAIL reset rd_data got %h want 0", rd_data); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL reset bus_err got %b want 0", bus_err); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset stall got %b want 0", stall); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_zero_wait_store();
        run_access("sw_zero_wait", 1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_byte();
        run_access("sb", 1'b1, F3_SB, 32'h103, 32'h1234_565A, 1, 0, 32'd0, 1'b0, 1'b0, 1'b1);
        run_access("lb", 1'b0, F3_LB, 32'h103, 32'd0, 0, 1, 32'h80FF_FFFF, 1'b0, 1'b0, 1'b1);
        n_checks++; if (rd_data !== 32'hFFFF_FF80) $display("FAIL lb_const rd_data got %h want ffffff80", rd_data); else n_pass++;
        run_access("lbu", 1'b0, F3_LBU, 32'h103, 32'd0, 0, 0, 32'h80FF_FFFF, 1'b0, 1'b0, 1'b1);
        n_checks++; if (rd_data !== 32'h0000_0080) $display("FAIL lbu_const rd_data got %h want 00000080", rd_data); else n_pass++;
    endtask

    task automatic test_half();
        run_access("lh_slow_ready", 1'b0, F3_LH, 32'h202, 32'd0, 5, 0, 32'h8001_1234, 1'b0, 1'b0, 1'b1);
        n_checks++; if (rd_data !== 32'hFFFF_8001) $display("FAIL lh_const rd_data got %h want ffff8001", rd_data); else n_pass++;
        run_access("lhu", 1'b0, F3_LHU, 32'h202, 32'd0, 0, 2, 32'h8001_1234, 1'b0, 1'b0, 1'b1);
        n_checks++; if (rd_data !== 32'h0000_8001) $display("FAIL lhu_const rd_data got %h want 00008001", rd_data); else n_pass++;
        run_access("sh", 1'b1, F3_SH, 32'h206, 32'hFFFF_BEEF, 2, 1, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_misaligned();
        logic        wr_tab [2] = '{1'b0, 1'b1};
        logic [2:0]  f3_tab [2] = '{F3_LW, F3_SH};
        logic [31:0] a_tab  [2] = '{32'h101, 32'h3};
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                mem_read = !wr_tab[i]; mem_write = wr_tab[i];
                funct3 = f3_tab[i]; addr = a_tab[i]; wr_data = $urandom;
                bus_if.bus_req_ready = 1'b1;
                #1;
                n_checks++; if (fault_misalign !== 1'b1) $display("FAIL misalign%0d fault c=%0d got %b want 1", i, c, fault_misalign); else n_pass++;
                n_checks++; if (stall !== 1'b0) $display("FAIL misalign%0d stall c=%0d got %b want 0", i, c, stall); else n_pass++;
                n_checks++; if (bus_if.bus_req_valid !== 1'b0) $display("FAIL misalign%0d req_valid c=%0d got %b want 0", i, c, bus_if.bus_req_valid); else n_pass++;
            end
            @(negedge clk);
            idle_inputs();
            $display("txn misaligned we=%0d f3=%0d addr=%h", wr_tab[i], f3_tab[i], a_tab[i]);
        end
    endtask

    task automatic test_errors();
        run_access("lw_rsp_err", 1'b0, F3_LW, 32'h300, 32'd0, 0, 1, 32'h1357_9BDF, 1'b1, 1'b0, 1'b1);
        run_access("sw_rsp_err", 1'b1, F3_SW, 32'h304, 32'hA5A5_0F0F, 1, 0, 32'd0, 1'b1, 1'b0, 1'b1);
        run_access("lw_timeout", 1'b0, F3_LW, 32'h308, 32'd0, 0, 0, 32'd0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL timeout_const rd_data got %h want 0", rd_data); else n_pass++;
        // Late response after the timeout must be ignored
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus_if.bus_rsp_valid = (c < 2);
            bus_if.bus_rsp_data  = 32'hFFFF_FFFF;
            bus_if.bus_rsp_err   = 1'b1;
            #1;
            n_checks++; if (bus_err !== 1'b0) $display("FAIL stray bus_err c=%0d got %b want 0", c, bus_err); else n_pass++;
            n_checks++; if (rd_data !== 32'd0) $display("FAIL stray rd_data c=%0d got %h want 0", c, rd_data); else n_pass++;
            n_checks++; if (bus_if.bus_req_valid !== 1'b0) $display("FAIL stray req_valid c=%0d got %b want 0", c, bus_if.bus_req_valid); else n_pass++;
        end
        idle_inputs();
        $display("txn stray response ignored");
    endtask

    task automatic test_back_to_back();
        run_access("b2b_sw", 1'b1, F3_SW, 32'h400, 32'h0102_0304, 0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
        run_access("b2b_lw", 1'b0, F3_LW, 32'h404, 32'd0, 0, 0, 32'h7766_5544, 1'b1, 1'b0, 1'b0);
        run_access("b2b_lbu", 1'b0, F3_LBU, 32'h405, 32'd0, 1, 0, 32'h7766_5544, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        run_access("preload", 1'b0, F3_LW, 32'h40, 32'd0, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
        // Reset while waiting for the response
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_LW; addr = 32'h80;
        @(negedge clk);
        bus_if.bus_req_ready = 1'b1;
        @(negedge clk);
        bus_if.bus_req_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (bus_if.bus_addr !== 32'd0) $display("FAIL rst_wait bus_addr got %h want 0", bus_if.bus_addr); else n_pass++;
        n_checks++; if (bus_if.bus_be !== 4'd0) $display("FAIL rst_wait bus_be got %b want 0000", bus_if.bus_be); else n_pass++;
        n_checks++; if (rd_data !== 32'd0) $display("FAIL rst_wait rd_data got %h want 0", rd_data); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL rst_wait bus_err got %b want 0", bus_err); else n_pass++;
        @(negedge clk);
        mem_read = 1'b0;
        reset = 1'b1;
        bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_data = 32'hFFFF_FFFF; bus_if.bus_rsp_err = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL rst_late stall got %b want 0", stall); else n_pass++;
        @(negedge clk);
        bus_if.bus_rsp_valid = 1'b0;
        #1;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL rst_late bus_err got %b want 0", bus_err); else n_pass++;
        n_checks++; if (rd_data !== 32'd0) $display("FAIL rst_late rd_data got %h want 0", rd_data); else n_pass++;
        n_checks++; if (bus_if.bus_req_valid !== 1'b0) $display("FAIL rst_late req_valid got %b want 0", bus_if.bus_req_valid); else n_pass++;
        // Reset while the request is pending: valid must drop at once
        @(negedge clk);
        mem_write = 1'b1; funct3 = F3_SW; addr = 32'h200; wr_data = 32'h1111_2222;
        @(negedge clk);
        #1;
        n_checks++; if (bus_if.bus_req_valid !== 1'b1) $display("FAIL rst_req pre req_valid got %b want 1", bus_if.bus_req_valid); else n_pass++;
        #1 reset = 1'b0;
        #1;
        n_checks++; if (bus_if.bus_req_valid !== 1'b0) $display("FAIL rst_req req_valid got %b want 0", bus_if.bus_req_valid); else n_pass++;
        n_checks++; if (bus_if.bus_we !== 1'b0) $display("FAIL rst_req bus_we got %b want 0", bus_if.bus_we); else n_pass++;
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        model_rd = 32'd0;
        $display("txn reset mid-transaction");
    endtask

    task automatic test_random();
        logic        is_wr;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            is_wr = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            case (f3[1:0])
                2'b00:   off = 2'($urandom_range(0, 3));
                2'b01:   off = {1'($urandom_range(0, 1)), 1'b0};
                default: off = 2'b00;
            endcase
            a = ($urandom & 32'hFFFF_FFFC) | {30'd0, off};
            run_access("rand", is_wr, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, TIMEOUT - 1),
                       $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_zero_wait_store();
        test_byte();
        test_half();
        test_misaligned();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store stage directly downstream of the single-cycle core's data-memory port (MemRead/MemWrite, address, write data, funct3).
- Converts each core access into one transaction on a valid/ready request and valid response data bus, with byte enables and lane alignment.
- Returns sign/zero-extended load data to the core.
- Holds the core with `stall` until the transaction completes; raises a fault for misaligned accesses and bus errors/timeouts.

Parameters:
- TIMEOUT, 255: cycles in WAIT_RSP without `bus_rsp_valid` before the access completes with an error. Range 1..65535.
- ADDR_WIDTH, 32: byte-address width for core and bus.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_read  in  1  core load request, level, held while stalled.
- mem_write  in  1  core store request, level, held while stalled.
- funct3  in  3  RISC-V load/store width/sign code.
- addr  in  ADDR_WIDTH  byte address from the ALU.
- wr_data  in  32  store data, right-justified.
- rd_data  out  32  extended load result, registered.
- stall  out  1  core must not advance pc.
- fault_misalign  out  1  combinational; misaligned access flagged.
- bus_err  out  1  registered one-cycle pulse; access failed.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  bus accepts request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00}).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-positioned write data.
- bus_rsp_valid  in  1  response valid; writes also respond.
- bus_rsp_data  in  32  read data, whole word.
- bus_rsp_err  in  1  response carries an error.

Behaviour:
- Reset values (reset=0, asynchronous):
  - state = IDLE.
  - bus_req_valid, bus_we, bus_err, bus_be = 0; bus_addr, bus_wdata, rd_data = 0.
  - timeout counter = 0.
- States: IDLE, REQ, WAIT_RSP, DONE. One outstanding transaction at most.
- Access decoding:
  - access = mem_read | mem_write. If both are set, the access is a write.
  - Size is funct3[1:0]: 00 byte, 01 half, 10/11 word.
  - Misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
- fault_misalign = access & misaligned, in any state. A misaligned access never issues a bus request and never stalls.
- stall = access & ~misaligned & (state != DONE).
- IDLE:
  - On access & ~misaligned, register bus_addr, bus_we, bus_be, bus_wdata, and the load size/sign and addr[1:0].
  - Set bus_req_valid = 1 and go to REQ.
- REQ:
  - Request fields are held stable while bus_req_valid & ~bus_req_ready.
  - When bus_req_ready = 1: clear bus_req_valid, clear the counter, go to WAIT_RSP.
- WAIT_RSP:
  - The counter increments each cycle.
  - On bus_rsp_valid: capture the extended load data into rd_data (loads only; stores leave rd_data unchanged), set bus_err = bus_rsp_err, go to DONE.
  - When counter == TIMEOUT-1 with no response: set rd_data = 0 and bus_err = 1, go to DONE.
- DONE:
  - Exactly one cycle with stall = 0, so the core retires the instruction at this edge.
  - bus_err is cleared on exit. Always returns to IDLE.
  - A back-to-back access is detected in the following IDLE cycle.
- Response outside WAIT_RSP (stray, or after a timeout) is ignored.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << {addr[1],1'b0}.
  - SW: 4'b1111.
- Write data lanes: byte replicated ×4, half replicated ×2, word as is.
- Load extraction:
  - Select the lane by the captured addr[1:0].
  - funct3 000 LB sign-extend, 001 LH sign-extend, 100 LBU zero-extend, 101 LHU zero-extend.
  - 010, 011, 11x are treated as LW.
- Zero-wait bus (ready=1 in REQ, response on the next cycle): 4 cycles per access, IDLE→REQ→WAIT_RSP→DONE, with stall high for the first 3.
- Reset mid-transaction: immediate return to IDLE, bus_req_valid drops asynchronously, and the late response is ignored.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW).
  - State enum lsu_state_t.
  - Size typedef lsu_size_t.
- Sub-module lsu_align, purely combinational: produces bus_be, bus_wdata and the misalign flag from size/addr/wr_data, and the extended load word from rsp_data/size/sign/offset. The FSM, counter and registers stay in lsu_bus_bridge.

Test Plan:
- Zero-wait store: SW addr=0x100, wr_data=0xDEADBEEF → bus_be=1111, bus_addr=0x100, bus_wdata=0xDEADBEEF; stall high 3 cycles, low in DONE.
- Byte store/load: SB addr=0x103, data=0x5A → be=1000, wdata=0x5A5A5A5A. LB addr=0x103 with rsp_data=0x80FF_FFFF → rd_data=0xFFFFFF80; LBU → 0x00000080.
- Halfword load: LH addr=0x202, rsp_data=0x8001_1234 → 0xFFFF8001; LHU → 0x00008001. Ready held low 5 cycles: request fields stable and stall high throughout.
- Misaligned: LW addr=0x101 → fault_misalign=1, stall=0, no bus_req_valid. SH addr=0x3 → same.
- Errors: bus_rsp_err=1 → bus_err pulses 1 cycle in DONE. With TIMEOUT=4 and no response → bus_err=1, rd_data=0, then a stray rsp_valid in IDLE is ignored.
- Reset asserted in WAIT_RSP → outputs at reset values immediately; a response arriving after release causes no state change.
